arrayn_flush: RTL and testbench

ARRAYN_FLUSH -- requirements
Module: arrayn_flush

---
 rtl/arrayn_flush.sv | 111 +++++++++++
 tb/tb_arrayn_flush.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrayn_flush.sv
// Byte-maskable register array with per-entry valid bits and a sequential flush sweep.
// Optional macro ARRAYN_WR_BYPASS_EN forwards write data to dataout/valid_out in the write cycle.
module arrayn_flush #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               write,
    input  logic [WIDTH/8-1:0] wmask,
    input  logic [IDX_W-1:0]   index,
    input  logic [WIDTH-1:0]   datain,
    output logic [WIDTH-1:0]   dataout,
    output logic               valid_out,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done
);

    localparam int NBYTES = WIDTH / 8;

    typedef enum logic [0:0] {IDLE, FLUSH} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic             flush_done_reg, done_next;
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [WIDTH-1:0] data_reg  [DEPTH];
    logic [WIDTH-1:0] data_next [DEPTH];
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                    ptr_next   = '0;
                end
            end
            FLUSH: begin
                if (ptr_reg == IDX_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    ptr_next = ptr_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // A write to the entry being swept takes priority over the clear.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic hit;
        logic clr;
        assign hit = write && (index == IDX_W'(gi));
        assign clr = (state_reg == FLUSH) && (ptr_reg == IDX_W'(gi));
        assign valid_next[gi] = hit ? 1'b1 : (clr ? 1'b0 : valid_reg[gi]);
        for (genvar gb = 0; gb < NBYTES; gb++) begin : g_byte
            assign data_next[gi][8*gb +: 8] = (hit && wmask[gb]) ? datain[8*gb +: 8]
                                                                 : data_reg[gi][8*gb +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            flush_done_reg <= 1'b0;
            valid_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            flush_done_reg <= done_next;
            valid_reg      <= valid_next;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= data_next[i];
            end
        end
    end

    assign rd_data    = data_reg[index];
    assign rd_valid   = valid_reg[index];
    assign flush_busy = (state_reg == FLUSH);
    assign flush_done = flush_done_reg;

`ifdef ARRAYN_WR_BYPASS_EN
    logic [WIDTH-1:0] byp_data;
    for (genvar gb = 0; gb < NBYTES; gb++) begin : g_byp
        assign byp_data[8*gb +: 8] = wmask[gb] ? datain[8*gb +: 8] : rd_data[8*gb +: 8];
    end
    assign dataout   = write ? byp_data : rd_data;
    assign valid_out = write | rd_valid;
`else
    assign dataout   = rd_data;
    assign valid_out = rd_valid;
`endif

endmodule

// File: tb/tb_arrayn_flush.sv
// Directed self-checking bench for arrayn_flush (WIDTH=128, DEPTH=4).
module tb_arrayn_flush;

    localparam int WIDTH = 128;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
`ifdef ARRAYN_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               write;
    logic [WIDTH/8-1:0] wmask;
    logic [IDX_W-1:0]   index;
    logic [WIDTH-1:0]   datain;
    logic [WIDTH-1:0]   dataout;
    logic               valid_out;
    logic               flush_req;
    logic               flush_busy;
    logic               flush_done;

    int errors = 0;
    int checks = 0;

    arrayn_flush #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .wmask(wmask), .index(index),
        .datain(datain), .dataout(dataout), .valid_out(valid_out),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pat(input int k);
        logic [7:0] b;
        b = 8'h11 * 8'(k + 1);
        return {16{b}};
    endfunction

    // Reads all valid bits by stepping index; write must be low.
    task automatic get_valid(output logic [DEPTH-1:0] v);
        logic [IDX_W-1:0] save;
        save = index;
        for (int i = 0; i < DEPTH; i++) begin
            index = IDX_W'(i);
            #1;
            v[i] = valid_out;
        end
        index = save;
        #1;
    endtask

    task automatic wr(input int idx, input logic [WIDTH-1:0] d, input logic [WIDTH/8-1:0] m);
        write = 1'b1; index = IDX_W'(idx); datain = d; wmask = m;
        tick();
        write = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; write = 1'b0; wmask = '0; index = '0; datain = '0; flush_req = 1'b0;
        tick(); tick();
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status busy=%b done=%b required 0 0", flush_busy, flush_done);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            index = IDX_W'(i);
            #1;
            checks++;
            if (dataout !== '0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_entry%0d data=%h valid=%b required 0 0", i, dataout, valid_out);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_mask();
        logic [WIDTH-1:0] exp;
        exp = {{8{8'h55}}, {8{8'hAA}}};
        wr(2, {16{8'hAA}}, 16'h00FF);
        wr(2, {16{8'h55}}, 16'hFF00);
        index = 2'd2;
        #1;
        checks++;
        if (dataout !== exp || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL mask_merge data=%h valid=%b required %h 1", dataout, valid_out, exp);
        end
        wr(0, {16{8'hFF}}, 16'h0000);
        index = 2'd0;
        #1;
        checks++;
        if (dataout !== '0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask data=%h valid=%b required 0 1", dataout, valid_out);
        end
        $display("test_mask done");
    endtask

    task automatic test_flush();
        logic [DEPTH-1:0] v;
        logic [DEPTH-1:0] exp;
        for (int i = 0; i < DEPTH; i++) wr(i, pat(i), '1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            get_valid(v);
            exp = 4'hF << k;
            checks++;
            if (flush_busy !== 1'b1 || flush_done !== 1'b0 || v !== exp) begin
                errors++;
                $display("FAIL flush_cycle%0d busy=%b done=%b valid=%b required 1 0 %b",
                         k, flush_busy, flush_done, v, exp);
            end
            tick();
        end
        get_valid(v);
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b1 || v !== 4'b0000) begin
            errors++;
            $display("FAIL flush_end busy=%b done=%b valid=%b required 0 1 0000", flush_busy, flush_done, v);
        end
        tick();
        checks++;
        if (flush_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b required 0", flush_done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            index = IDX_W'(i);
            #1;
            checks++;
            if (dataout !== pat(i)) begin
                errors++;
                $display("FAIL flush_data%0d data=%h required %h", i, dataout, pat(i));
            end
        end
        $display("test_flush done");
    endtask

    task automatic test_flush_write();
        logic [DEPTH-1:0] v;
        logic [DEPTH-1:0] exp [5];
        exp[0] = 4'b1111; exp[1] = 4'b1110; exp[2] = 4'b1110; exp[3] = 4'b1010; exp[4] = 4'b0010;
        for (int i = 0; i < DEPTH; i++) wr(i, pat(i), '1);
        flush_req = 1'b1;
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            get_valid(v);
            checks++;
            if (flush_busy !== 1'b1 || v !== exp[k]) begin
                errors++;
                $display("FAIL fw_cycle%0d busy=%b valid=%b required 1 %b", k, flush_busy, v, exp[k]);
            end
            if (k == 1) begin
                write = 1'b1; index = 2'd1; datain = pat(7); wmask = '1;
            end
            tick();
            write = 1'b0;
        end
        flush_req = 1'b0;
        get_valid(v);
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b1 || v !== exp[4]) begin
            errors++;
            $display("FAIL fw_end busy=%b done=%b valid=%b required 0 1 %b", flush_busy, flush_done, v, exp[4]);
        end
        tick();
        checks++;
        if (flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL fw_no_restart busy=%b required 0", flush_busy);
        end
        $display("test_flush_write done");
    endtask

    task automatic test_back_to_back();
        int n;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (DEPTH) tick();
        checks++;
        if (flush_done !== 1'b1 || flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first done=%b busy=%b required 1 0", flush_done, flush_busy);
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (flush_busy !== 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n !== DEPTH || flush_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second busy_cycles=%0d done=%b required %0d 1", n, flush_done, DEPTH);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < DEPTH; i++) wr(i, pat(i), '1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_async busy=%b done=%b required 0 0", flush_busy, flush_done);
        end
        write = 1'b1; flush_req = 1'b1; index = 2'd0; datain = '1; wmask = '1;
        tick();
        write = 1'b0; flush_req = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            index = IDX_W'(i);
            #1;
            checks++;
            if (dataout !== '0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL abort_entry%0d data=%h valid=%b required 0 0", i, dataout, valid_out);
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle%0d done=%b busy=%b required 0 0", c, flush_done, flush_busy);
            end
        end
        $display("test_reset_abort done");
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_same;
        logic             exp_vld;
        exp_same = BYP ? WIDTH'(16'h1234) : '0;
        exp_vld  = BYP;
        write = 1'b1; index = 2'd3; datain = WIDTH'(16'h1234); wmask = '1;
        #1;
        checks++;
        if (dataout !== exp_same || valid_out !== exp_vld) begin
            errors++;
            $display("FAIL bypass_same data=%h valid=%b required %h %b", dataout, valid_out, exp_same, exp_vld);
        end
        tick();
        write = 1'b0;
        #1;
        checks++;
        if (dataout !== WIDTH'(16'h1234) || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bypass_next data=%h valid=%b required 1234 1", dataout, valid_out);
        end
        $display("test_bypass done");
    endtask

    initial begin
        test_reset();
        test_mask();
        test_flush();
        test_flush_write();
        test_back_to_back();
        test_reset_abort();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
